// File: rtl/p405s_icu_va_ctl.sv
// rtl/p405s_icu_va_ctl.sv - ICU fetch virtual-address register load sequencer
// Optional saturating miss counter: P405S_ICU_VA_MISSCNT_EN.
module p405s_icu_va_ctl #(
  parameter int unsigned FETCH_BYTES = 8,
  parameter logic [0:31] RESET_VEC   = 32'hFFFF_FFFC
) (
  input  logic        CB,
  input  logic        resetN,
  input  logic        redirVal,
  input  logic [0:31] redirAddr,
  input  logic        haltReq,
  input  logic        fetchGo,
  input  logic        missDet,
  input  logic        fillDone,
  input  logic [0:31] vaL2,
  output logic [0:31] vaD,
  output logic        vaE1,
  output logic        fetchVal,
  output logic        missPend,
  output logic        missCancel,
  output logic [0:15] missCnt
);

  typedef enum logic [1:0] {ST_RUN, ST_MISS, ST_REPLAY, ST_HALT} state_t;

  localparam logic [0:31] LP_STEP       = 32'(FETCH_BYTES);
  localparam logic [0:31] LP_ALIGN_MASK = ~(LP_STEP - 32'd1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_fetch_val;
  logic        w_fetch_val_nxt;
  logic        r_miss_pend;
  logic        w_miss_pend_nxt;
  logic        r_miss_cancel;
  logic        w_miss_cancel_nxt;
  logic [0:31] w_seq_addr;

  // Sequential fetch always steps to the next aligned block, wrapping at 2^32.
  assign w_seq_addr = (vaL2 & LP_ALIGN_MASK) + LP_STEP;

  always_comb begin
    vaE1              = 1'b0;
    vaD               = vaL2;
    w_state_nxt       = r_state;
    w_fetch_val_nxt   = r_fetch_val;
    w_miss_pend_nxt   = r_miss_pend;
    w_miss_cancel_nxt = 1'b0;
    if (!resetN) begin
      vaE1 = 1'b1;
      vaD  = RESET_VEC;
    end else if (redirVal) begin
      vaE1              = 1'b1;
      vaD               = redirAddr;
      w_state_nxt       = haltReq ? ST_HALT : ST_RUN;
      w_fetch_val_nxt   = !haltReq;
      w_miss_pend_nxt   = 1'b0;
      w_miss_cancel_nxt = (r_state == ST_MISS) || (r_state == ST_REPLAY);
    end else begin
      unique case (r_state)
        ST_RUN: begin
          // missDet/fetchGo only mean something while an address is being offered.
          if (missDet && r_fetch_val) begin
            w_state_nxt     = ST_MISS;
            w_miss_pend_nxt = 1'b1;
            w_fetch_val_nxt = 1'b0;
          end else if (fetchGo && r_fetch_val) begin
            vaE1 = 1'b1;
            vaD  = w_seq_addr;
          end else if (haltReq) begin
            w_state_nxt     = ST_HALT;
            w_fetch_val_nxt = 1'b0;
          end else begin
            w_fetch_val_nxt = 1'b1;
          end
        end
        ST_MISS: begin
          if (fillDone) begin
            w_state_nxt     = ST_REPLAY;
            w_miss_pend_nxt = 1'b0;
          end
        end
        ST_REPLAY: begin
          w_state_nxt     = haltReq ? ST_HALT : ST_RUN;
          w_fetch_val_nxt = !haltReq;
        end
        ST_HALT: begin
          w_fetch_val_nxt = 1'b0;
          if (!haltReq) begin
            w_state_nxt     = ST_RUN;
            w_fetch_val_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CB) begin
    if (!resetN) begin
      r_state       <= ST_RUN;
      r_fetch_val   <= 1'b0;
      r_miss_pend   <= 1'b0;
      r_miss_cancel <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_val   <= w_fetch_val_nxt;
      r_miss_pend   <= w_miss_pend_nxt;
      r_miss_cancel <= w_miss_cancel_nxt;
    end
  end

  assign fetchVal   = r_fetch_val;
  assign missPend   = r_miss_pend;
  assign missCancel = r_miss_cancel;

`ifdef P405S_ICU_VA_MISSCNT_EN
  logic [0:15] r_miss_cnt;
  logic        w_miss_start;

  // Counted on entry to MISS, so a miss later aborted by redirect still counts.
  assign w_miss_start = resetN && !redirVal && (r_state == ST_RUN) && (w_state_nxt == ST_MISS);

  always_ff @(posedge CB) begin
    if (!resetN) begin
      r_miss_cnt <= '0;
    end else if (w_miss_start && (r_miss_cnt != 16'hFFFF)) begin
      r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign missCnt = r_miss_cnt;
`else
  assign missCnt = '0;
`endif

endmodule

// File: tb/tb_p405s_icu_va_ctl.sv
// tb/tb_p405s_icu_va_ctl.sv - directed and randomized bench for p405s_icu_va_ctl
// Miss-counter expectations follow P405S_ICU_VA_MISSCNT_EN.
module tb_p405s_icu_va_ctl;

  localparam int unsigned FB = 8;
  localparam logic [31:0] RV = 32'hFFFF_FFFC;

  logic        CB = 1'b0;
  logic        resetN, redirVal, haltReq, fetchGo, missDet, fillDone;
  logic [0:31] redirAddr, vaL2, vaD;
  logic        vaE1, fetchVal, missPend, missCancel;
  logic [0:15] missCnt;

  always #5 CB = ~CB;

  p405s_icu_va_ctl #(.FETCH_BYTES(FB), .RESET_VEC(RV)) dut (
    .CB(CB), .resetN(resetN), .redirVal(redirVal), .redirAddr(redirAddr),
    .haltReq(haltReq), .fetchGo(fetchGo), .missDet(missDet), .fillDone(fillDone),
    .vaL2(vaL2), .vaD(vaD), .vaE1(vaE1), .fetchVal(fetchVal), .missPend(missPend),
    .missCancel(missCancel), .missCnt(missCnt)
  );

  // Stand-in for the enable-load VA register.
  always @(posedge CB) if (vaE1) vaL2 <= vaD;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_addr;
  bit          m_fv, m_mp, m_mc, m_missing, m_replay, m_halted;
  int unsigned m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rstn, rv, input logic [31:0] ra, input bit hr, fg, md, fd);
    m_mc = 1'b0;
    if (!rstn) begin
      m_addr = RV; m_fv = 0; m_mp = 0; m_cnt = 0;
      m_missing = 0; m_replay = 0; m_halted = 0;
    end else if (rv) begin
      m_addr = ra;
      m_mc = m_missing || m_replay;
      m_mp = 0; m_missing = 0; m_replay = 0;
      m_halted = hr; m_fv = !hr;
    end else if (m_missing) begin
      if (fd) begin m_missing = 0; m_replay = 1; m_mp = 0; end
    end else if (m_replay) begin
      m_replay = 0; m_halted = hr; m_fv = !hr;
    end else if (m_halted) begin
      if (!hr) begin m_halted = 0; m_fv = 1; end
    end else if (md && m_fv) begin
      m_missing = 1; m_mp = 1; m_fv = 0;
`ifdef P405S_ICU_VA_MISSCNT_EN
      if (m_cnt < 65535) m_cnt++;
`endif
    end else if (fg && m_fv) begin
      m_addr = m_addr - (m_addr % FB) + FB;
    end else if (hr) begin
      m_halted = 1; m_fv = 0;
    end else begin
      m_fv = 1;
    end
  endtask

  task automatic cyc(input bit rstn, rv, input logic [31:0] ra, input bit hr, fg, md, fd);
    resetN = rstn; redirVal = rv; redirAddr = ra;
    haltReq = hr; fetchGo = fg; missDet = md; fillDone = fd;
    model_step(rstn, rv, ra, hr, fg, md, fd);
    @(posedge CB);
    #1;
    chk("vaL2", vaL2, m_addr);
    chk("fetchVal", 32'(fetchVal), 32'(m_fv));
    chk("missPend", 32'(missPend), 32'(m_mp));
    chk("missCancel", 32'(missCancel), 32'(m_mc));
    chk("missCnt", 32'(missCnt), m_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  bit hr_l;

  initial begin
    // Reset held 3 cycles; load path is forced while in reset.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_vaE1", 32'(vaE1), 32'd1);
    chk("rst_vaD", vaD, RV);
    chk("rst_fetchVal", 32'(fetchVal), 32'd0);
    idle(1);
    chk("rel_vaL2", vaL2, 32'hFFFF_FFFC);
    chk("rel_fetchVal", 32'(fetchVal), 32'd1);
    cyc(1, 0, 0, 0, 1, 0, 0); chk("seq_wrap", vaL2, 32'h0000_0000);
    cyc(1, 0, 0, 0, 1, 0, 0); chk("seq_08", vaL2, 32'h0000_0008);
    cyc(1, 0, 0, 0, 1, 0, 0); chk("seq_10", vaL2, 32'h0000_0010);
    cyc(1, 0, 0, 0, 1, 0, 0); chk("seq_18", vaL2, 32'h0000_0018);

    // Miss with simultaneous fetchGo, fill, replay.
    cyc(1, 1, 32'h0000_1000, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    chk("miss_hold", vaL2, 32'h0000_1000);
    chk("miss_pend", 32'(missPend), 32'd1);
    chk("miss_fv", 32'(fetchVal), 32'd0);
    idle(4);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("replay_fv", 32'(fetchVal), 32'd0);
    idle(1);
    chk("replay_fv1", 32'(fetchVal), 32'd1);
    chk("replay_addr", vaL2, 32'h0000_1000);

    // Redirect aborts outstanding miss.
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 1, 32'h0000_2004, 0, 0, 0, 0);
    chk("cancel_addr", vaL2, 32'h0000_2004);
    chk("cancel_pulse", 32'(missCancel), 32'd1);
    chk("cancel_pend", 32'(missPend), 32'd0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("cancel_once", 32'(missCancel), 32'd0);
    chk("cancel_next", vaL2, 32'h0000_2008);

    // Halt and release, then redirect while halted.
    cyc(1, 0, 0, 1, 0, 0, 0);
    chk("halt_fv", 32'(fetchVal), 32'd0);
    chk("halt_addr", vaL2, 32'h0000_2008);
    idle(1);
    chk("unhalt_fv", 32'(fetchVal), 32'd1);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 32'h0000_3000, 1, 0, 0, 0);
    chk("halt_redir_addr", vaL2, 32'h0000_3000);
    chk("halt_redir_fv", 32'(fetchVal), 32'd0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    chk("halt_stays", 32'(fetchVal), 32'd0);
    idle(1);
    chk("halt_exit", 32'(fetchVal), 32'd1);

    // Reset mid-miss.
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rstmiss_addr", vaL2, 32'hFFFF_FFFC);
    chk("rstmiss_pend", 32'(missPend), 32'd0);
    chk("rstmiss_cancel", 32'(missCancel), 32'd0);
    idle(1);

    // Randomized traffic against the model.
    hr_l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) hr_l = ~hr_l;
      cyc($urandom_range(63) != 0, $urandom_range(7) == 0, $urandom,
          hr_l, $urandom_range(1) == 1, $urandom_range(4) == 0, $urandom_range(3) == 0);
    end

`ifdef P405S_ICU_VA_MISSCNT_EN
    idle(1);
    for (int i = 0; i < 65540; i++) begin
      cyc(1, 0, 0, 0, 0, 1, 0);
      cyc(1, 1, 32'h0000_4000, 0, 0, 0, 0);
    end
    chk("cnt_sat", 32'(missCnt), 32'h0000_FFFF);
`else
    chk("cnt_off", 32'(missCnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p405s_icu_va_ctl.md
# p405s_icu_va_ctl

Sequencer for the ICU fetch virtual-address register, the 32-bit enable-load register built on p405s_PDP_P1EUL2. It decides each cycle whether that register loads and from which source: the reset vector, a branch/interrupt redirect, or the sequential next-fetch address. It holds the address across cache misses and re-presents it after line fill. It sits between the fetch-redirect logic and the ICU array-access pipeline.

## Interface
- FETCH_BYTES, 8: bytes per fetch; power of two, 4..32; sequential increment.
- RESET_VEC, 32'hFFFF_FFFC: address loaded during reset.
- CB  in  1  core clock; all state updates on rising edge.
- resetN  in  1  reset; synchronous, active-low.
- redirVal  in  1  redirect request, single-cycle qualifier.
- redirAddr  in  [0:31]  redirect target.
- haltReq  in  1  level; stop issuing fetches.
- fetchGo  in  1  ICU accepted the current fetch address this cycle.
- missDet  in  1  current fetch missed; valid only while fetchVal=1.
- fillDone  in  1  line fill complete, single-cycle pulse.
- vaL2  in  [0:31]  current register output (L2), fed back.
- vaD  out  [0:31]  register D input; combinational.
- vaE1  out  1  register load enable; combinational.
- fetchVal  out  1  address in register is valid for fetch; registered.
- missPend  out  1  miss outstanding; registered.
- missCancel  out  1  one-cycle pulse: redirect aborted an outstanding miss; registered.
- missCnt  out  [0:15]  miss counter (see Configuration).

## Operation
- States: RUN, MISS, REPLAY, HALT. Encoding is free.
- Reset (resetN=0 at edge): state<=RUN. fetchVal, missPend and missCancel are cleared to 0. While resetN=0, vaE1=1 and vaD=RESET_VEC. The register therefore holds RESET_VEC on the first cycle after reset.
- First cycle after reset release: fetchVal=1.
- Load priority each cycle, highest first: reset, redirVal, missDet, fetchGo.
- Any state, redirVal=1:
  - vaE1=1, vaD=redirAddr.
  - Next state is RUN, or HALT if haltReq=1.
  - From MISS or REPLAY, missCancel=1 next cycle and missPend clears.
- RUN:
  - missDet=1: vaE1=0, next state MISS, missPend<=1, fetchVal<=0. A simultaneous fetchGo is ignored.
  - Else fetchGo=1: vaE1=1, vaD = (vaL2 & ~(FETCH_BYTES-1)) + FETCH_BYTES, modulo 2^32. The sum wraps FFFF_FFF8 to 0000_0000 with no flag.
  - Else haltReq=1: next state HALT, fetchVal<=0.
  - Otherwise hold with vaE1=0.
- MISS: vaE1=0. On fillDone, next state REPLAY and missPend<=0. fetchGo and missDet are ignored.
- REPLAY: one cycle, vaE1=0, address unchanged.
  - Next state RUN with fetchVal<=1.
  - If haltReq=1, next state HALT instead, fetchVal stays 0.
- HALT: vaE1=0, fetchVal=0. When haltReq=0, next state RUN and fetchVal<=1 with the address unchanged.
- When vaE1=0, vaD is don't-care; drive it as vaL2.

## Timing
- Redirect in cycle n: vaL2=redirAddr and fetchVal=1 in cycle n+1.
- fetchGo in cycle n: next address appears on vaL2 in n+1. Back-to-back fetchGo gives one address per cycle.
- missDet in cycle n: fetchVal=0 from n+1.
- fillDone in cycle m: REPLAY in m+1, fetchVal=1 in m+2, same address re-presented.
- fillDone and redirVal in the same cycle: the redirect wins and missCancel=1 in the next cycle.
- resetN low in any state, including mid-miss: reset takes effect at the next edge, and missCancel is not asserted.
- The only combinational input-to-output paths are to vaD and vaE1.

## Configuration
- P405S_ICU_VA_MISSCNT_EN defined:
  - missCnt is a 16-bit counter, cleared by reset.
  - It increments on each RUN-to-MISS transition and saturates at 16'hFFFF.
  - A miss aborted by redirect still counts.
- Undefined: missCnt is tied to 0 and no counter flops exist.

## Test plan
- Reset held 3 cycles, then released, then fetchGo for 4 cycles:
  - After release, vaL2=FFFF_FFFC and fetchVal=1.
  - The first fetchGo gives 0000_0000 (wrap); the following give 0000_0008, 0000_0010, 0000_0018.
- At vaL2=0000_1000, assert missDet and fetchGo together:
  - Register holds 0000_1000, missPend=1, fetchVal=0.
  - fillDone 5 cycles later: REPLAY, then fetchVal=1 at 0000_1000.
- During MISS, assert redirVal with redirAddr=0000_2004:
  - Next cycle vaL2=0000_2004, missCancel=1 for exactly one cycle, missPend=0.
  - Then fetchGo gives 0000_2008, the aligned next address.
- In RUN, assert haltReq with fetchGo=0:
  - fetchVal=0 and the address is held.
  - Deassert haltReq: fetchVal=1 next cycle at the same address.
  - Repeat with redirVal during HALT while haltReq stays 1: the address loads and the state stays HALT.
- Assert resetN=0 mid-MISS: next cycle state is RUN, vaL2=FFFF_FFFC, missPend=0, missCancel=0.
- With P405S_ICU_VA_MISSCNT_EN, force 65,540 misses: missCnt=FFFF. Without the macro: missCnt=0.
